kim_counter_ctrl: RTL and testbench
===================================

Name: kim_counter_ctrl

Overview:
- Control stage directly upstream of the team's free-running enable/clear counter (`kim_counter`).
- Drives that counter's `cnt_en` and `init_cnt`, watches its `cnt` output, and turns it into a programmable one-shot or periodic timer with start/stop/pause control and a done pulse.
- Sits between the register/command interface and the counter instance; both live under a thin top wrapper.

Parameters:
- CNT_DATA_WIDTH, 7, width of the counter value and terminal count; must match the downstream counter.
- PERIOD_W, 8, width of the completed-period counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  start request; acted on only in IDLE.
- stop  in  1  abort request; clears the counter and returns to IDLE.
- pause  in  1  level; freezes counting while high in RUN.
- mode_repeat  in  1  0 = one-shot, 1 = periodic; latched on accepted start.
- tc_val  in  CNT_DATA_WIDTH  terminal count; latched on accepted start.
- cnt  in  CNT_DATA_WIDTH  current value from the downstream counter.
- cnt_en  out  1  counter enable to the downstream counter.
- init_cnt  out  1  counter clear to the downstream counter; meaningful only with cnt_en=1.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse per completed period, registered.
- period_cnt  out  PERIOD_W  completed periods since start (optional feature).

Behaviour:
- Reset: synchronous, active-low. On a clock edge with rst_n=0:
  - state <= IDLE; done, tc_q, mode_q and period_cnt <= 0.
  - Combinational outputs then decode to cnt_en=0, init_cnt=0, busy=0.
- FSM states: IDLE, CLEAR, RUN. State is registered; cnt_en and init_cnt are a combinational decode of state, the pause input and the terminal compare, so the counter sees them in the same cycle.
- Terminal compare: term = (cnt == tc_q), full CNT_DATA_WIDTH equality, no arithmetic.
- IDLE:
  - Outputs: cnt_en=0, init_cnt=0.
  - start=1 and stop=0 -> latch tc_q <= tc_val and mode_q <= mode_repeat, then go to CLEAR.
  - stop=1 has priority over start; the block stays in IDLE.
- CLEAR (always exactly one cycle):
  - Outputs: cnt_en=1, init_cnt=1, so the counter reads 0 on the next cycle.
  - pause is ignored. stop=1 -> IDLE, otherwise -> RUN.
- RUN: priority is stop > pause > term.
  - stop=1: cnt_en=1, init_cnt=1 (counter cleared), go to IDLE, no done pulse.
  - pause=1: cnt_en=0, init_cnt=0, stay in RUN; term is ignored while paused.
  - term=1 with mode_q=1: cnt_en=1, init_cnt=1, stay in RUN, done <= 1 next cycle.
  - term=1 with mode_q=0: cnt_en=1, init_cnt=1, go to IDLE, done <= 1 next cycle.
  - Otherwise: cnt_en=1, init_cnt=0 (counter increments).
- Period length: tc_q+1 RUN cycles. Special cases:
  - tc_val=0 gives a period of 1 cycle; in repeat mode done is high every cycle.
  - tc_val = 2^W-1 is legal; the counter never wraps because it is cleared at the terminal count.
- Latency:
  - One-shot: start sampled at edge N -> CLEAR in cycle N+1 -> RUN cycles N+2 .. N+2+tc -> done high in cycle N+3+tc, with busy already low.
- start while busy is ignored. tc_val and mode_repeat changes while busy are ignored.
- A mid-run reset forces IDLE with the outputs deasserted. The downstream counter's own reset clears cnt.

Optional Feature:
- Macro: KIM_COUNTER_CTRL_PERIOD_CNT_EN.
- Defined:
  - period_cnt clears to 0 on an accepted start.
  - It increments on every cycle in which done is set, and saturates at 2^PERIOD_W-1.
- Undefined: the port still exists, tied to 0, and no register is inferred.

Decomposition:
- Package kim_counter_pkg holds:
  - the state enum (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2);
  - the default widths CNT_DATA_WIDTH_DEF=7 and PERIOD_W_DEF=8.
- No sub-module inside kim_counter_ctrl. The separate wrapper kim_counter_top instantiates kim_counter_ctrl and kim_counter with shared clk/rst_n.

Test Plan:
- One-shot, W=7, tc_val=4, start pulse in cycle 0 -> cnt_en high for cycles 1-6 (init_cnt in cycles 1 and 6), cnt 0,1,2,3,4 then 0, done high in cycle 7 only, busy low from cycle 7.
- Repeat, tc_val=4, run 20 cycles -> cnt cycles through 0..4, done every 5 cycles, period_cnt=3 after the fourth done is pending (macro on) or 0 (macro off).
- Pause asserted for 3 cycles when cnt=2 -> cnt holds at 2 for 3 cycles, then resumes; done is delayed by exactly 3 cycles.
- stop asserted when cnt=3 -> init_cnt=1 that cycle, cnt=0 next, IDLE, no done; start and stop together in IDLE -> stays IDLE.
- tc_val=0 repeat -> done high every cycle after the first RUN cycle; tc_val=127 one-shot -> done 130 cycles after start with no wrap.
- Reset (rst_n=0 for 1 cycle) mid-RUN -> next cycle busy=0, cnt_en=0, done=0, period_cnt=0; start change to tc_val during RUN does not affect period.

Source files
------------

// File: rtl/kim_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kim_counter_pkg
// Description : Shared state encoding and default widths for the counter
//               control stage.
// Revision    : 1.0 - initial release
// ============================================================================
package kim_counter_pkg;

    localparam int CNT_DATA_WIDTH_DEF = 7;
    localparam int PERIOD_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/kim_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : kim_counter_ctrl_if
// Description : Command/status and counter-side signal bundle of the counter
//               control stage. The slave modport is the controller's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface kim_counter_ctrl_if #(
    parameter int CNT_DATA_WIDTH = kim_counter_pkg::CNT_DATA_WIDTH_DEF,
    parameter int PERIOD_W       = kim_counter_pkg::PERIOD_W_DEF
);
    logic                      start;
    logic                      stop;
    logic                      pause;
    logic                      mode_repeat;
    logic [CNT_DATA_WIDTH-1:0] tc_val;
    logic [CNT_DATA_WIDTH-1:0] cnt;
    logic                      cnt_en;
    logic                      init_cnt;
    logic                      busy;
    logic                      done;
    logic [PERIOD_W-1:0]       period_cnt;

    modport master (
        output start, stop, pause, mode_repeat, tc_val, cnt,
        input  cnt_en, init_cnt, busy, done, period_cnt
    );

    modport slave (
        input  start, stop, pause, mode_repeat, tc_val, cnt,
        output cnt_en, init_cnt, busy, done, period_cnt
    );
endinterface
`default_nettype wire

// File: rtl/kim_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kim_counter_ctrl
// Description : One-shot / periodic timer control for the downstream
//               enable/clear counter. Optional completed-period counter is
//               enabled with macro KIM_COUNTER_CTRL_PERIOD_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kim_counter_ctrl #(
    parameter int CNT_DATA_WIDTH = kim_counter_pkg::CNT_DATA_WIDTH_DEF,
    parameter int PERIOD_W       = kim_counter_pkg::PERIOD_W_DEF
) (
    input  wire              clk,
    input  wire              rst_n,
    kim_counter_ctrl_if.slave bus
);
    import kim_counter_pkg::*;

    state_t                    r_state;
    logic [CNT_DATA_WIDTH-1:0] r_tc_q;
    logic                      r_mode_q;
    logic                      r_done;

    logic w_term;
    logic w_accept;
    logic w_done_set;
    logic w_cnt_en;
    logic w_init_cnt;

    assign w_term     = (bus.cnt == r_tc_q);
    assign w_accept   = (r_state == IDLE) && bus.start && !bus.stop;
    assign w_done_set = (r_state == RUN) && !bus.stop && !bus.pause && w_term;

    // Counter controls are decoded in the same cycle so the counter reacts
    // to the terminal count without an extra cycle of slip.
    always_comb begin
        w_cnt_en   = 1'b0;
        w_init_cnt = 1'b0;
        case (r_state)
            CLEAR: begin
                w_cnt_en   = 1'b1;
                w_init_cnt = 1'b1;
            end
            RUN: begin
                if (bus.stop) begin
                    w_cnt_en   = 1'b1;
                    w_init_cnt = 1'b1;
                end else if (bus.pause) begin
                    w_cnt_en   = 1'b0;
                    w_init_cnt = 1'b0;
                end else begin
                    w_cnt_en   = 1'b1;
                    w_init_cnt = w_term;
                end
            end
            default: begin
                w_cnt_en   = 1'b0;
                w_init_cnt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tc_q   <= '0;
            r_mode_q <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done_set;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tc_q   <= bus.tc_val;
                        r_mode_q <= bus.mode_repeat;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_state <= bus.stop ? IDLE : RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                    end else if (!bus.pause && w_term && !r_mode_q) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef KIM_COUNTER_CTRL_PERIOD_CNT_EN
    logic [PERIOD_W-1:0] r_period_cnt;

    // Steps together with done so the count already includes the pending pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
        end else if (w_accept) begin
            r_period_cnt <= '0;
        end else if (w_done_set && (r_period_cnt != {PERIOD_W{1'b1}})) begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    assign bus.period_cnt = r_period_cnt;
`else
    assign bus.period_cnt = {PERIOD_W{1'b0}};
`endif

    assign bus.cnt_en   = w_cnt_en;
    assign bus.init_cnt = w_init_cnt;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_kim_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kim_counter_ctrl
// Description : Directed scoreboard bench for kim_counter_ctrl with a
//               behavioural model of the downstream counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kim_counter_ctrl;

    localparam int W  = 7;
    localparam int PW = 8;

    typedef struct {
        int         cyc;
        logic [7:0] pc;
    } done_ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   c0;

    done_ev_t sb[$];
    done_ev_t mon_e;

    kim_counter_ctrl_if #(.CNT_DATA_WIDTH(W), .PERIOD_W(PW)) bus ();

    kim_counter_ctrl #(.CNT_DATA_WIDTH(W), .PERIOD_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counter model
    always @(posedge clk) begin
        if (!rst_n)                bus.cnt <= '0;
        else if (bus.cnt_en === 1'b1) bus.cnt <= (bus.init_cnt === 1'b1) ? '0 : bus.cnt + 1'b1;
    end

    function automatic logic [7:0] exp_pc(int n);
`ifdef KIM_COUNTER_CTRL_PERIOD_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int n);
        done_ev_t e;
        e.cyc = c;
        e.pc  = exp_pc(n);
        sb.push_back(e);
    endtask

    task automatic launch(input int tc, input bit rep, output int c);
        bus.tc_val      = W'(tc);
        bus.mode_repeat = rep;
        bus.start       = 1'b1;
        c = cyc;
    endtask

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL done_missing: got no pulse expected pulse at cycle %0d", sb[0].cyc);
            mon_e = sb.pop_front();
        end
        if (bus.done === 1'b1) begin
            checks++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                failures++;
                $display("FAIL done_unexpected @cyc %0d: got 1 expected 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.period_cnt !== mon_e.pc) begin
                    failures++;
                    $display("FAIL done_period_cnt @cyc %0d: got %0d expected %0d",
                             cyc, bus.period_cnt, mon_e.pc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        bus.mode_repeat = 1'b0; bus.tc_val = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.cnt_en, 0);
        chk("rst_init", bus.init_cnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pc", bus.period_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // One-shot, tc=4
        launch(4, 0, c0);
        push(c0 + 7, 1);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("s1_en",   bus.cnt_en,   (k >= 1 && k <= 6) ? 1 : 0);
            chk("s1_init", bus.init_cnt, (k == 1 || k == 6) ? 1 : 0);
            chk("s1_busy", bus.busy,     (k >= 1 && k <= 6) ? 1 : 0);
            if (k >= 2 && k <= 7) chk("s1_cnt", bus.cnt, (k == 7) ? 0 : k - 2);
            tick();
            bus.start = 1'b0;
        end

        // Repeat, tc=4, then stop
        launch(4, 1, c0);
        for (int i = 0; i < 4; i++) push(c0 + 7 + 5 * i, i + 1);
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 23) chk("s2_cnt", bus.cnt, (k - 2) % 5);
            if (k == 21) chk("s2_pc_pending", bus.period_cnt, exp_pc(3));
            if (k == 24) chk("s2_stop_init", bus.init_cnt, 1);
            if (k == 25) begin
                chk("s2_busy", bus.busy, 0);
                chk("s2_cnt_clr", bus.cnt, 0);
            end
            tick();
            bus.start = 1'b0;
            bus.stop  = (k == 23);
        end

        // Pause for three cycles at cnt=2
        launch(4, 0, c0);
        push(c0 + 10, 1);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k >= 4 && k <= 6) chk("s3_pause_en", bus.cnt_en, 0);
            if (k == 7) chk("s3_hold", bus.cnt, 2);
            if (k == 9) chk("s3_term", bus.cnt, 4);
            if (k == 10) chk("s3_busy", bus.busy, 0);
            tick();
            bus.start = 1'b0;
            bus.pause = (k >= 3 && k <= 5);
        end

        // Stop at cnt=3, no done
        launch(4, 0, c0);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("s4_cnt3", bus.cnt, 3);
                chk("s4_en", bus.cnt_en, 1);
                chk("s4_init", bus.init_cnt, 1);
            end
            if (k == 6) begin
                chk("s4_busy", bus.busy, 0);
                chk("s4_cnt0", bus.cnt, 0);
            end
            tick();
            bus.start = 1'b0;
            bus.stop  = (k == 4);
        end
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        @(negedge clk);
        chk("s4_startstop_busy", bus.busy, 0);
        tick(); tick();

        // tc=0 repeat: done every cycle
        launch(0, 1, c0);
        for (int i = 0; i < 6; i++) push(c0 + 3 + i, i + 1);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) chk("s5_init", bus.init_cnt, 1);
            if (k == 9) chk("s5_busy", bus.busy, 0);
            tick();
            bus.start = 1'b0;
            bus.stop  = (k == 7);
        end

        // tc=0 repeat long enough to saturate period_cnt
        launch(0, 1, c0);
        for (int i = 0; i < 260; i++) push(c0 + 3 + i, i + 1);
        for (int k = 0; k <= 264; k++) begin
            @(negedge clk);
            tick();
            bus.start = 1'b0;
            bus.stop  = (k == 261);
        end

        // tc=127 one-shot, no wrap
        launch(127, 0, c0);
        push(c0 + 130, 1);
        for (int k = 0; k <= 131; k++) begin
            @(negedge clk);
            if (k == 129) chk("s5_cnt_max", bus.cnt, 127);
            if (k == 130) begin
                chk("s5_cnt_nowrap", bus.cnt, 0);
                chk("s5_busy_max", bus.busy, 0);
            end
            tick();
            bus.start = 1'b0;
        end

        // Reset mid-RUN
        launch(4, 1, c0);
        push(c0 + 7, 1);
        push(c0 + 12, 2);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 15) begin
                chk("s6_busy", bus.busy, 0);
                chk("s6_en", bus.cnt_en, 0);
                chk("s6_done", bus.done, 0);
                chk("s6_pc", bus.period_cnt, 0);
            end
            tick();
            bus.start = 1'b0;
            rst_n = !(k == 13);
        end

        // tc/mode changes while busy are ignored
        launch(3, 0, c0);
        push(c0 + 6, 1);
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            if (k == 5) chk("s7_cnt", bus.cnt, 3);
            if (k == 6) chk("s7_busy", bus.busy, 0);
            tick();
            bus.start = 1'b0;
            if (k == 2) begin
                bus.tc_val = W'(10);
                bus.mode_repeat = 1'b1;
            end
        end

        tick(); tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
